// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Each grant lasts at most BURST_MAX beats; one idle bubble separates consecutive grants.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       w_valid,
    output logic [WIDTH-1:0]           data_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(BURST_MAX + 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(BURST_MAX - 1);
    localparam logic [IdW-1:0]  LastId   = IdW'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  owner_q, owner_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

    logic            pick_found;
    logic [IdW-1:0]  pick_idx;
    int unsigned     scan_idx;
    logic            owner_valid;

    // First requester strictly after the last released owner, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!pick_found && req_valid[IdW'(scan_idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IdW'(scan_idx);
            end
        end
    end

    assign owner_valid = req_valid[owner_q];
    assign grant_id    = owner_q;
    assign busy        = (state_q == StGrant);

    always_comb begin
        req_ready = '0;
        w_valid   = 1'b0;
        data_in   = '0;
        if (state_q == StGrant) begin
            req_ready[owner_q] = !fifo_full;
            w_valid            = owner_valid && !fifo_full;
            if (w_valid) begin
                data_in = req_data[32'(owner_q) * WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                // A full FIFO freezes the grant, even if the owner withdraws.
                if (!fifo_full) begin
                    if (!owner_valid || beat_cnt_q == LastBeat) begin
                        state_d  = StIdle;
                        rr_ptr_d = owner_q;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= LastId;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: modelled producers, and a scoreboard of the
// expected FIFO write stream in arrival order.
module tb_fifo_wr_arbiter;

    localparam int W = 32;
    localparam int N = 4;
    localparam int D = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           w_valid;
    logic [W-1:0]   data_in;
    logic [1:0]     grant_id;
    logic           busy;

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .w_valid   (w_valid),
        .data_in   (data_in),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [N][D];
    int          head [N];
    int          tail [N];
    logic [N-1:0] fire;
    logic        rst_nxt;
    logic        full_nxt;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int id, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            mem[id][tail[id]] = base + 32'(k);
            tail[id]++;
        end
    endtask

    task automatic push(input int id, input logic [31:0] base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = id;
            e.data = base + 32'(k);
            exp_q.push_back(e);
        end
    endtask

    // One clock: retire last cycle's handshakes, drive inputs, then sample mid-cycle.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (fire[i] && head[i] != tail[i]) head[i]++;
        reset     = rst_nxt;
        fifo_full = full_nxt;
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = (head[i] != tail[i]);
            req_data[i*W +: W]   = req_valid[i] ? mem[i][head[i]] : '0;
        end
        @(negedge clk);
        fire = req_valid & req_ready;
        if (w_valid) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
            end else begin
                e.id   = -1;
                e.data = 32'hBAD0_BAD0;
            end
            check("sb_data", data_in, e.data);
            check("sb_grant_id", {30'b0, grant_id}, e.id);
        end else begin
            check("idle_data_in", data_in, 32'h0);
        end
    endtask

    task automatic step(input logic ewv, input logic ebusy, input logic [3:0] erdy);
        cycle();
        check("w_valid", {31'b0, w_valid}, {31'b0, ewv});
        check("busy", {31'b0, busy}, {31'b0, ebusy});
        check("req_ready", {28'b0, req_ready}, {28'b0, erdy});
    endtask

    task automatic reset_pulse();
        rst_nxt = 1'b1;
        cycle();
        rst_nxt = 1'b0;
    endtask

    task automatic drain();
        int budget;
        int left;
        budget = 300;
        left   = 1;
        while (left != 0 && budget > 0) begin
            cycle();
            budget--;
            left = exp_q.size();
            for (int i = 0; i < N; i++) left += tail[i] - head[i];
        end
        check("drain_left", 32'(left), 32'h0);
        cycle();
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        fire      = '0;
        reset     = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rst_nxt   = 1'b1;
        full_nxt  = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held with every producer requesting; first grant goes to 0.
        for (int i = 0; i < N; i++) load(i, 32'h10 + 32'(i), 1);
        for (int i = 0; i < N; i++) push(i, 32'h10 + 32'(i), 1);
        repeat (3) step(1'b0, 1'b0, 4'b0000);
        rst_nxt = 1'b0;
        step(1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0001);
        drain();

        // Single producer, 6 words: 4-beat burst, bubble, re-grant for the rest.
        load(2, 32'hA0, 6);
        push(2, 32'hA0, 6);
        step(1'b0, 1'b0, 4'b0000);
        repeat (4) step(1'b1, 1'b1, 4'b0100);
        step(1'b0, 1'b0, 4'b0000);
        repeat (2) step(1'b1, 1'b1, 4'b0100);
        step(1'b0, 1'b1, 4'b0100);
        step(1'b0, 1'b0, 4'b0000);

        // Full contention: two rounds of 0,1,2,3 with 4 beats each.
        reset_pulse();
        for (int i = 0; i < N; i++) load(i, 32'((i + 1) << 8), 8);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 32'((i + 1) << 8) + 32'(r * 4), 4);
        drain();

        // Backpressure for 3 cycles after beat 2 of producer 1.
        reset_pulse();
        load(1, 32'h1100, 4);
        load(2, 32'h2200, 4);
        push(1, 32'h1100, 4);
        push(2, 32'h2200, 4);
        step(1'b0, 1'b0, 4'b0000);
        repeat (2) step(1'b1, 1'b1, 4'b0010);
        full_nxt = 1'b1;
        repeat (3) begin
            step(1'b0, 1'b1, 4'b0000);
            check("bp_grant_id", {30'b0, grant_id}, 32'd1);
        end
        full_nxt = 1'b0;
        repeat (2) step(1'b1, 1'b1, 4'b0010);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0100);
        drain();

        // Early release: producer 0 runs dry after 2 beats, producer 3 waiting.
        reset_pulse();
        load(0, 32'h5000, 2);
        load(3, 32'h5300, 2);
        push(0, 32'h5000, 2);
        push(3, 32'h5300, 2);
        step(1'b0, 1'b0, 4'b0000);
        repeat (2) step(1'b1, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b0, 4'b0000);
        repeat (2) step(1'b1, 1'b1, 4'b1000);
        step(1'b0, 1'b1, 4'b1000);
        step(1'b0, 1'b0, 4'b0000);

        // Reset during beat 2 of producer 1; that beat still lands.
        reset_pulse();
        load(1, 32'h6100, 4);
        push(1, 32'h6100, 2);
        push(0, 32'h6000, 2);
        push(1, 32'h6102, 2);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0010);
        rst_nxt = 1'b1;
        step(1'b1, 1'b1, 4'b0010);
        rst_nxt = 1'b0;
        load(0, 32'h6000, 2);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0001);
        drain();

        check("sb_remaining", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
